// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the registered add/subtract block
//
// Purpose: op encoding and default operand width shared by adder and add_core.
// Ports:   none (package).

package adder_pkg;

  localparam int   DEFAULT_N = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_core.sv
// rtl/add_core.sv - combinational N-bit add/subtract with carry/borrow and signed overflow
//
// Purpose: pure arithmetic datapath; subtract is formed as a + ~b + 1.
// Ports:
//   a, b      [N-1:0] operands (unsigned or two's-complement)
//   op        0 = add, 1 = subtract
//   sum       [N-1:0] result modulo 2^N
//   carry     carry-out on add, borrow (a < b) on subtract
//   overflow  signed two's-complement overflow

module add_core
  import adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   full;

  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;

  // The carry-in of one completes the two's-complement negation of b.
  assign full = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
  assign sum  = full[N-1:0];

  // With a + ~b + 1 the raw carry-out means "no borrow", so invert it on subtract.
  assign carry = full[N] ^ is_sub;

  // Overflow when both effective addends share a sign that the result does not.
  assign overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/adder.sv
// rtl/adder.sv - one-cycle-latency registered add/subtract unit
//
// Purpose: samples operands when in_valid is high and presents the result one
//          cycle later; results hold while no new operation arrives.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op are valid this cycle
//   op         0 = add, 1 = subtract
//   a, b       [N-1:0] operands
//   out_valid  registered copy of in_valid
//   c          [N-1:0] registered result
//   carry      registered carry / borrow
//   overflow   registered signed overflow

module adder
  import adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] c,
  output logic         carry,
  output logic         overflow
);

  logic [N-1:0] sum_d;
  logic         carry_d;
  logic         overflow_d;

  add_core #(.N(N)) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .sum      (sum_d),
    .carry    (carry_d),
    .overflow (overflow_d)
  );

  // Result registers load only on a valid operation, so idle cycles (including
  // undriven operands) leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c        <= sum_d;
        carry    <= carry_d;
        overflow <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - self-checking bench for adder at widths 1, 4 and 8

module tb_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;

  logic       v1, cy1, ov1;
  logic [0:0] c1;
  logic       v4, cy4, ov4;
  logic [3:0] c4;
  logic       v8, cy8, ov8;
  logic [7:0] c8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adder #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a[0:0]), .b(b[0:0]),
    .out_valid(v1), .c(c1), .carry(cy1), .overflow(ov1)
  );
  adder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a[3:0]), .b(b[3:0]),
    .out_valid(v4), .c(c4), .carry(cy4), .overflow(ov4)
  );
  adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out_valid(v8), .c(c8), .carry(cy8), .overflow(ov8)
  );

  function automatic int width_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  // Reference: exact integer arithmetic, then reduce. Unsigned carry/borrow
  // from the exact unsigned result, overflow from the exact signed result.
  function automatic void model(input int n, input int av, input int bv, input bit o,
                                output int rc, output bit rcy, output bit rov);
    int m, ua, ub, sa, sb, r, sr;
    m  = 1 << n;
    ua = av % m;
    ub = bv % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (o) begin
      r   = ua - ub;
      sr  = sa - sb;
      rcy = (r < 0);
    end else begin
      r   = ua + ub;
      sr  = sa + sb;
      rcy = (r >= m);
    end
    rc  = ((r % m) + m) % m;
    rov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endfunction

  int exp_c[3]  = '{0, 0, 0};
  bit exp_v[3]  = '{0, 0, 0};
  bit exp_cy[3] = '{0, 0, 0};
  bit exp_ov[3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_v[i] = 0; exp_c[i] = 0; exp_cy[i] = 0; exp_ov[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_v[i] = in_valid;
        if (in_valid) model(width_of(i), int'(a), int'(b), op, exp_c[i], exp_cy[i], exp_ov[i]);
      end
    end
  end

  task automatic cmp(input string nm, input int i, input bit v, input int cv,
                     input bit cy, input bit ov);
    checks++;
    if (v !== exp_v[i] || cv != exp_c[i] || cy !== exp_cy[i] || ov !== exp_ov[i]) begin
      errors++;
      $display("FAIL %s @%0t: got v=%0d c=%0d carry=%0d ovf=%0d, want v=%0d c=%0d carry=%0d ovf=%0d",
               nm, $time, v, cv, cy, ov, exp_v[i], exp_c[i], exp_cy[i], exp_ov[i]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_w1", 0, v1, int'(c1), cy1, ov1);
      cmp("model_w4", 1, v4, int'(c4), cy4, ov4);
      cmp("model_w8", 2, v8, int'(c8), cy8, ov8);
    end
  end

  task automatic lit(input string nm, input int w, input bit ev, input int ec,
                     input bit ecy, input bit eov);
    bit v, cy, ov;
    int cv;
    case (w)
      1:       begin v = v1; cv = int'(c1); cy = cy1; ov = ov1; end
      4:       begin v = v4; cv = int'(c4); cy = cy4; ov = ov4; end
      default: begin v = v8; cv = int'(c8); cy = cy8; ov = ov8; end
    endcase
    checks++;
    if (v !== ev || cv != ec || cy !== ecy || ov !== eov) begin
      errors++;
      $display("FAIL %s w%0d: got v=%0d c=%0d carry=%0d ovf=%0d, want v=%0d c=%0d carry=%0d ovf=%0d",
               nm, w, v, cv, cy, ov, ev, ec, ecy, eov);
    end
  endtask

  task automatic step(input bit v, input int av, input int bv, input bit o);
    @(negedge clk);
    in_valid = v;
    a  = av[7:0];
    b  = bv[7:0];
    op = o;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int w; int a; int b; bit op; int c; bit cy; bit ov;
  } vec_t;

  vec_t vecs[13] = '{
    '{1, 0, 0, 0, 0, 0, 0},
    '{1, 0, 1, 0, 1, 0, 0},
    '{1, 1, 0, 0, 1, 0, 0},
    '{1, 1, 1, 0, 0, 1, 1},
    '{1, 0, 0, 1, 0, 0, 0},
    '{1, 0, 1, 1, 1, 1, 1},
    '{1, 1, 0, 1, 1, 0, 0},
    '{1, 1, 1, 1, 0, 0, 0},
    '{4, 7, 1, 0, 8, 0, 1},
    '{4, 15, 15, 0, 14, 1, 0},
    '{4, 3, 5, 1, 14, 1, 0},
    '{4, 8, 1, 1, 7, 0, 1},
    '{4, 0, 1, 1, 15, 1, 0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
    #3;
    lit("reset", 1, 0, 0, 0, 0);
    lit("reset", 4, 0, 0, 0, 0);
    lit("reset", 8, 0, 0, 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    foreach (vecs[i])
    begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      lit($sformatf("vec%0d", i), vecs[i].w, 1'b1, vecs[i].c, vecs[i].cy, vecs[i].ov);
    end

    // Valid gating: result from the first op must hold through the idle cycle.
    step(1'b1, 2, 3, 1'b0);
    lit("gate_v1", 4, 1, 5, 0, 0);
    step(1'b0, 9, 9, 1'b0);
    lit("gate_hold", 4, 0, 5, 0, 0);
    step(1'b1, 4, 4, 1'b1);
    lit("gate_v2", 4, 1, 0, 0, 0);

    // Reset between edges while a result is presented.
    step(1'b1, 3, 2, 1'b0);
    lit("pre_rst", 4, 1, 5, 0, 0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    lit("rst_mid", 4, 0, 0, 0, 0);
    lit("rst_mid", 8, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 6, 1, 1'b0);
    lit("post_rst", 4, 1, 7, 0, 0);

    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      if (errors != 0) break;
    end

    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
